muskbus_rr_arbiter: RTL and testbench

- Shares one Muskbus top port between N bottom requesters, for example the I-cache, D-cache and page walker.
- Uses round-robin fairness with a registered grant.
- A granted requester keeps ownership until it drops bid.
- Request and response signals are routed only to and from the current owner.
- A tenure counter asks a long-holding owner to yield while other requesters are waiting.

---
 rtl/muskbus_rr_arbiter.sv | 164 ++++++++++++++++
 tb/tb_muskbus_rr_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muskbus_rr_arbiter.sv
// muskbus_rr_arbiter
//   Shares one upstream Muskbus port between N bottom requesters using
//   round-robin arbitration with a registered grant. A granted requester
//   keeps ownership until it drops its bid. Every release passes through
//   IDLE, so there is exactly one idle turnaround cycle between owners.
//   A saturating tenure counter asks a long-holding owner to yield when
//   other requesters are waiting. The arbiter never preempts.
//
// FSM states:
//   state | meaning
//   IDLE  | no owner; search bids from rr_ptr for the next winner
//   GRANT | owner is routed to/from the top port; tenure counts owned cycles
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   bot_bid[N]          per-requester bid (held for the whole tenure)
//   bot_reqcyc[N]       per-requester request valid
//   bot_req[N*DATA_W]   request data, slice i = requester i
//   bot_reqtag[N*TAG_W] request tag, slice i = requester i
//   bot_respack[N]      per-requester response acknowledge
//   bot_reqack[N]       request acknowledge back to the owner
//   bot_respcyc[N]      response valid to the owner
//   bot_resp[N*DATA_W]  response data to the owner's slice
//   bot_yield[N]        yield request to the owner
//   top_*               upstream port, driven from the owner's signals
//   grant[N]            one-hot owner, zero in IDLE
//   busy                high while in GRANT
module muskbus_rr_arbiter #(
  parameter int N          = 4,
  parameter int DATA_W     = 64,
  parameter int TAG_W      = 13,
  parameter int MAX_TENURE = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        bot_bid,
  input  logic [N-1:0]        bot_reqcyc,
  input  logic [N*DATA_W-1:0] bot_req,
  input  logic [N*TAG_W-1:0]  bot_reqtag,
  input  logic [N-1:0]        bot_respack,
  output logic [N-1:0]        bot_reqack,
  output logic [N-1:0]        bot_respcyc,
  output logic [N*DATA_W-1:0] bot_resp,
  output logic [N-1:0]        bot_yield,
  output logic                top_bid,
  output logic                top_reqcyc,
  output logic [DATA_W-1:0]   top_req,
  output logic [TAG_W-1:0]    top_reqtag,
  output logic                top_respack,
  input  logic                top_reqack,
  input  logic                top_respcyc,
  input  logic [DATA_W-1:0]   top_resp,
  output logic [N-1:0]        grant,
  output logic                busy
);

  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (MAX_TENURE > 0) ? $clog2(MAX_TENURE + 1) : 1;
  localparam logic [TW-1:0] TEN_MAX = TW'(MAX_TENURE);
  localparam logic [OW-1:0] LAST    = OW'(N - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   owner, owner_nxt;
  logic [OW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [TW-1:0]   tenure, tenure_nxt;

  logic            win_found;
  logic [OW-1:0]   win_idx;
  logic [OW-1:0]   idx;
  logic [N-1:0]    owner_oh;
  logic            others_bid;
  logic            tenure_up;

  // Round-robin search: first bid at rr_ptr, rr_ptr+1, ... wrapping at N-1
  // (N need not be a power of two, so the wrap is explicit).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = rr_ptr;
    for (int k = 0; k < N; k++) begin
      if (!win_found && bot_bid[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
      idx = (idx == LAST) ? '0 : idx + OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      tenure <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
      tenure <= tenure_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    tenure_nxt = tenure;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt  = GRANT;
          owner_nxt  = win_idx;
          rr_ptr_nxt = (win_idx == LAST) ? '0 : win_idx + OW'(1);
          tenure_nxt = '0;
        end
      end
      GRANT: begin
        // Release always goes through IDLE, even if another bid is waiting.
        if (!bot_bid[owner]) begin
          state_nxt = IDLE;
        end else if (tenure != TEN_MAX) begin
          tenure_nxt = tenure + TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign owner_oh   = N'(1) << owner;
  assign others_bid = |(bot_bid & ~owner_oh);
  assign tenure_up  = (MAX_TENURE != 0) && (tenure >= TEN_MAX);

  // Routing depends only on registered state/owner, never directly on bid.
  // It stays active in the release cycle so a late response still lands.
  always_comb begin
    bot_reqack  = '0;
    bot_respcyc = '0;
    bot_resp    = '0;
    bot_yield   = '0;
    top_bid     = 1'b0;
    top_reqcyc  = 1'b0;
    top_req     = '0;
    top_reqtag  = '0;
    top_respack = 1'b0;
    grant       = '0;
    busy        = 1'b0;
    if (state == GRANT) begin
      busy                            = 1'b1;
      grant                           = owner_oh;
      top_bid                         = bot_bid[owner];
      top_reqcyc                      = bot_reqcyc[owner];
      top_req                         = bot_req[owner*DATA_W +: DATA_W];
      top_reqtag                      = bot_reqtag[owner*TAG_W +: TAG_W];
      top_respack                     = bot_respack[owner];
      bot_reqack[owner]               = top_reqack;
      bot_respcyc[owner]              = top_respcyc;
      bot_resp[owner*DATA_W +: DATA_W] = top_resp;
      bot_yield[owner]                = tenure_up && others_bid;
    end
  end

endmodule

// File: tb/tb_muskbus_rr_arbiter.sv
// tb_muskbus_rr_arbiter
//   Directed bench for muskbus_rr_arbiter. Three instances share the clock
//   and reset: dut (N=4, MAX_TENURE=8), dut_z (N=4, MAX_TENURE=0, same
//   inputs as dut) and dut_3 (N=3, MAX_TENURE=256, own bids).
module tb_muskbus_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int TG = 13;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      bot_bid, bot_reqcyc, bot_respack;
  logic [N*DW-1:0]   bot_req;
  logic [N*TG-1:0]   bot_reqtag;
  logic              top_reqack, top_respcyc;
  logic [DW-1:0]     top_resp;

  logic [N-1:0]      bot_reqack, bot_respcyc, bot_yield, grant;
  logic [N*DW-1:0]   bot_resp;
  logic              top_bid, top_reqcyc, top_respack, busy;
  logic [DW-1:0]     top_req;
  logic [TG-1:0]     top_reqtag;

  logic [N-1:0]      bot_reqack_z, bot_respcyc_z, bot_yield_z, grant_z;
  logic [N*DW-1:0]   bot_resp_z;
  logic              top_bid_z, top_reqcyc_z, top_respack_z, busy_z;
  logic [DW-1:0]     top_req_z;
  logic [TG-1:0]     top_reqtag_z;

  logic [2:0]        b3_bid;
  logic [2:0]        bot_reqack_3, bot_respcyc_3, bot_yield_3, grant_3;
  logic [3*DW-1:0]   bot_resp_3;
  logic              top_bid_3, top_reqcyc_3, top_respack_3, busy_3;
  logic [DW-1:0]     top_req_3;
  logic [TG-1:0]     top_reqtag_3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muskbus_rr_arbiter #(.N(4), .DATA_W(DW), .TAG_W(TG), .MAX_TENURE(8)) dut (
    .clk(clk), .reset(reset),
    .bot_bid(bot_bid), .bot_reqcyc(bot_reqcyc), .bot_req(bot_req),
    .bot_reqtag(bot_reqtag), .bot_respack(bot_respack),
    .bot_reqack(bot_reqack), .bot_respcyc(bot_respcyc), .bot_resp(bot_resp),
    .bot_yield(bot_yield), .top_bid(top_bid), .top_reqcyc(top_reqcyc),
    .top_req(top_req), .top_reqtag(top_reqtag), .top_respack(top_respack),
    .top_reqack(top_reqack), .top_respcyc(top_respcyc), .top_resp(top_resp),
    .grant(grant), .busy(busy)
  );

  muskbus_rr_arbiter #(.N(4), .DATA_W(DW), .TAG_W(TG), .MAX_TENURE(0)) dut_z (
    .clk(clk), .reset(reset),
    .bot_bid(bot_bid), .bot_reqcyc(bot_reqcyc), .bot_req(bot_req),
    .bot_reqtag(bot_reqtag), .bot_respack(bot_respack),
    .bot_reqack(bot_reqack_z), .bot_respcyc(bot_respcyc_z), .bot_resp(bot_resp_z),
    .bot_yield(bot_yield_z), .top_bid(top_bid_z), .top_reqcyc(top_reqcyc_z),
    .top_req(top_req_z), .top_reqtag(top_reqtag_z), .top_respack(top_respack_z),
    .top_reqack(top_reqack), .top_respcyc(top_respcyc), .top_resp(top_resp),
    .grant(grant_z), .busy(busy_z)
  );

  muskbus_rr_arbiter #(.N(3), .DATA_W(DW), .TAG_W(TG), .MAX_TENURE(256)) dut_3 (
    .clk(clk), .reset(reset),
    .bot_bid(b3_bid), .bot_reqcyc(3'b000), .bot_req({3*DW{1'b0}}),
    .bot_reqtag({3*TG{1'b0}}), .bot_respack(3'b000),
    .bot_reqack(bot_reqack_3), .bot_respcyc(bot_respcyc_3), .bot_resp(bot_resp_3),
    .bot_yield(bot_yield_3), .top_bid(top_bid_3), .top_reqcyc(top_reqcyc_3),
    .top_req(top_req_3), .top_reqtag(top_reqtag_3), .top_respack(top_respack_3),
    .top_reqack(top_reqack), .top_respcyc(top_respcyc), .top_resp(top_resp),
    .grant(grant_3), .busy(busy_3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    reset       = 1'b1;
    bot_bid     = '0;
    bot_reqcyc  = '0;
    bot_respack = '0;
    bot_req     = '0;
    bot_reqtag  = '0;
    top_reqack  = 1'b0;
    top_respcyc = 1'b0;
    top_resp    = '0;
    b3_bid      = '0;
    step();
    step();
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_top_bid", 64'(top_bid), 64'h0);
    chk("rst_top_req", top_req, 64'h0);
    reset = 1'b0;

    // single requester 2
    step(); step(); step();
    bot_bid               = 4'b0100;
    bot_reqcyc            = 4'b0100;
    bot_respack           = 4'b0100;
    bot_req[2*DW +: DW]   = 64'hDEAD_BEEF;
    bot_req[0*DW +: DW]   = 64'h1111;
    bot_reqtag[2*TG +: TG] = 13'h1ABC;
    #1;
    chk("single_no_comb_grant", 64'(grant), 64'h0);
    chk("single_no_comb_req", top_req, 64'h0);
    step();
    chk("single_grant", 64'(grant), 64'b0100);
    chk("single_busy", 64'(busy), 64'h1);
    chk("single_top_bid", 64'(top_bid), 64'h1);
    chk("single_top_req", top_req, 64'hDEAD_BEEF);
    chk("single_top_reqtag", 64'(top_reqtag), 64'h1ABC);
    chk("single_top_reqcyc", 64'(top_reqcyc), 64'h1);
    chk("single_top_respack", 64'(top_respack), 64'h1);
    top_reqack  = 1'b1;
    top_respcyc = 1'b1;
    top_resp    = 64'h55;
    #1;
    chk("single_reqack", 64'(bot_reqack), 64'b0100);
    chk("single_respcyc", 64'(bot_respcyc), 64'b0100);
    chk("single_resp2", bot_resp[2*DW +: DW], 64'h55);
    chk("single_resp0", bot_resp[0*DW +: DW], 64'h0);
    bot_bid     = 4'b0000;
    top_reqack  = 1'b0;
    top_respcyc = 1'b0;
    step();
    chk("single_release", 64'(grant), 64'h0);

    // round robin, rr_ptr starts at 0 after reset
    reset = 1'b1;
    step();
    reset   = 1'b0;
    bot_bid = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      e = r % 4;
      step();
      chk("rr_grant_c1", 64'(grant), 64'd1 << e);
      step();
      chk("rr_grant_c2", 64'(grant), 64'd1 << e);
      step();
      chk("rr_grant_c3", 64'(grant), 64'd1 << e);
      chk("rr_yield", 64'(bot_yield), 64'h0);
      bot_bid[e] = 1'b0;
      step();
      chk("rr_idle_gap", 64'(grant), 64'h0);
      chk("rr_idle_busy", 64'(busy), 64'h0);
      bot_bid = 4'b1111;
    end
    // owner 0 now, rr_ptr = 1
    step();
    bot_bid = 4'b0000;
    step();
    chk("rr_end_idle", 64'(grant), 64'h0);

    // release-cycle response to owner 1
    bot_bid = 4'b0010;
    step();
    chk("rel_grant", 64'(grant), 64'b0010);
    bot_bid     = 4'b0000;
    top_respcyc = 1'b1;
    top_resp    = 64'h1234;
    #1;
    chk("rel_respcyc", 64'(bot_respcyc), 64'b0010);
    chk("rel_resp1", bot_resp[1*DW +: DW], 64'h1234);
    chk("rel_top_bid", 64'(top_bid), 64'h0);
    step();
    chk("rel_idle", 64'(grant), 64'h0);
    chk("rel_idle_respcyc", 64'(bot_respcyc), 64'h0);
    chk("rel_idle_resp", bot_resp[1*DW +: DW], 64'h0);
    top_respcyc = 1'b0;

    // yield with MAX_TENURE=8
    bot_bid = 4'b0001;
    step();
    chk("y_grant", 64'(grant), 64'b0001);
    for (int t = 1; t < 4; t++) begin
      step();
      chk("y_early", 64'(bot_yield), 64'h0);
    end
    step();
    bot_bid = 4'b1001;
    #1;
    chk("y_t4", 64'(bot_yield), 64'h0);
    for (int t = 5; t < 8; t++) begin
      step();
      chk("y_below_max", 64'(bot_yield), 64'h0);
    end
    step();
    chk("y_at_max", 64'(bot_yield), 64'b0001);
    chk("y_disabled", 64'(bot_yield_z), 64'h0);
    chk("y_no_preempt", 64'(grant), 64'b0001);
    step();
    chk("y_saturated", 64'(bot_yield), 64'b0001);
    chk("y_disabled2", 64'(bot_yield_z), 64'h0);
    bot_bid = 4'b1000;
    step();
    chk("y_idle", 64'(grant), 64'h0);
    chk("y_idle_yield", 64'(bot_yield), 64'h0);
    step();
    chk("y_next_owner", 64'(grant), 64'b1000);
    chk("y_new_owner_yield", 64'(bot_yield), 64'h0);

    // reset mid-grant
    bot_bid = 4'b0000;
    step();
    bot_bid = 4'b0100;
    step();
    chk("rm_grant", 64'(grant), 64'b0100);
    top_respcyc = 1'b1;
    top_resp    = 64'hABCD;
    #1;
    chk("rm_respcyc_pre", 64'(bot_respcyc), 64'b0100);
    reset = 1'b1;
    step();
    chk("rm_grant0", 64'(grant), 64'h0);
    chk("rm_busy0", 64'(busy), 64'h0);
    chk("rm_respcyc0", 64'(bot_respcyc), 64'h0);
    chk("rm_resp0", bot_resp[2*DW +: DW], 64'h0);
    chk("rm_top_bid0", 64'(top_bid), 64'h0);
    chk("rm_top_reqcyc0", 64'(top_reqcyc), 64'h0);
    reset       = 1'b0;
    top_respcyc = 1'b0;
    bot_bid     = 4'b0101;
    step();
    chk("rm_ptr_zero", 64'(grant), 64'b0001);

    // N=3 wrap
    bot_bid = 4'b0000;
    reset   = 1'b1;
    step();
    reset  = 1'b0;
    b3_bid = 3'b111;
    for (int r = 0; r < 4; r++) begin
      e = r % 3;
      step();
      chk("n3_grant", 64'(grant_3), 64'd1 << e);
      b3_bid[e] = 1'b0;
      step();
      chk("n3_idle", 64'(grant_3), 64'h0);
      b3_bid = 3'b111;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
